// File: rtl/sig_gen_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the poly-voice signal generator: waveform shape
// codes, register map, CTRL field layout, FSM states and the reciprocal
// table used by the mixer normaliser.
package sig_gen_pkg;

  typedef enum logic [1:0] {
    SHAPE_SAW_UP = 2'd0,
    SHAPE_SAW_DN = 2'd1,
    SHAPE_TRI    = 2'd2,
    SHAPE_SQUARE = 2'd3
  } shape_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NORM  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_FREQ = 2'd0;
  localparam logic [1:0] ADDR_AMP  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  localparam int CTRL_SHAPE_LSB = 0;
  localparam int CTRL_DUTY_LSB  = 2;
  localparam int CTRL_EN_BIT    = 31;

  localparam int RECIP_W = 17;

  // round(65536 / n) for n = 1..16; 0 for unused codes.
  function automatic logic [RECIP_W-1:0] recip_lut(input logic [4:0] n);
    logic [RECIP_W-1:0] r;
    case (n)
      5'd1:    r = 17'd65536;
      5'd2:    r = 17'd32768;
      5'd3:    r = 17'd21845;
      5'd4:    r = 17'd16384;
      5'd5:    r = 17'd13107;
      5'd6:    r = 17'd10923;
      5'd7:    r = 17'd9362;
      5'd8:    r = 17'd8192;
      5'd9:    r = 17'd7282;
      5'd10:   r = 17'd6554;
      5'd11:   r = 17'd5958;
      5'd12:   r = 17'd5461;
      5'd13:   r = 17'd5041;
      5'd14:   r = 17'd4681;
      5'd15:   r = 17'd4369;
      5'd16:   r = 17'd4096;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sig_wave_shaper.sv
`timescale 1ns/1ps
// Combinational waveform shaper: turns one voice's phase, shape, duty and
// amplitude into a signed, amplitude-scaled sample. Shared by all voices
// through the voice multiplexer in the top level.
module sig_wave_shaper
  import sig_gen_pkg::*;
#(
  parameter int PHASE_W  = 32,
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 16,
  parameter int DUTY_W   = 8
) (
  input  logic [PHASE_W-1:0]         phase_i,
  input  logic [1:0]                 shape_i,
  input  logic [DUTY_W-1:0]          duty_i,
  input  logic [AMP_W-1:0]           amp_i,
  output logic signed [SAMPLE_W-1:0] scaled_o
);

  localparam int PROD_W = SAMPLE_W + AMP_W + 1;
  localparam logic [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SQ_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

  logic [SAMPLE_W-1:0]      p_s;
  logic [DUTY_W-1:0]        p_duty_s;
  logic [SAMPLE_W-1:0]      saw_s;
  logic [SAMPLE_W-1:0]      tri_q_s;
  logic [SAMPLE_W-1:0]      wave_s;
  logic [PROD_W-1:0]        wave_ext_s;
  logic [PROD_W-1:0]        amp_ext_s;
  logic signed [PROD_W-1:0] prod_s;

  // Waveform selection followed by signed x unsigned amplitude scaling (floor)
  always_comb begin
    p_s      = SAMPLE_W'(phase_i >> (PHASE_W - SAMPLE_W));
    p_duty_s = DUTY_W'(phase_i >> (PHASE_W - DUTY_W));
    saw_s    = {~p_s[SAMPLE_W-1], p_s[SAMPLE_W-2:0]};
    tri_q_s  = p_s[SAMPLE_W-1] ? ~{p_s[SAMPLE_W-2:0], 1'b0} : {p_s[SAMPLE_W-2:0], 1'b0};
    case (shape_e'(shape_i))
      SHAPE_SAW_UP: wave_s = saw_s;
      SHAPE_SAW_DN: wave_s = ~saw_s;
      SHAPE_TRI:    wave_s = {~tri_q_s[SAMPLE_W-1], tri_q_s[SAMPLE_W-2:0]};
      SHAPE_SQUARE: wave_s = (p_duty_s < duty_i) ? SQ_POS : SQ_NEG;
      default:      wave_s = saw_s;
    endcase
    wave_ext_s = {{(AMP_W+1){wave_s[SAMPLE_W-1]}}, wave_s};
    amp_ext_s  = {{(SAMPLE_W+1){1'b0}}, amp_i};
    prod_s     = $signed(wave_ext_s) * $signed(amp_ext_s);
    scaled_o   = SAMPLE_W'(prod_s >>> AMP_W);
  end

endmodule

// File: rtl/poly_sig_gen.sv
`timescale 1ns/1ps
// Multi-voice signal generator with mixer. Holds per-voice register files
// and phase accumulators, walks the voices one per cycle after each sample
// tick, and averages the active voices into one saturated signed sample.
module poly_sig_gen
  import sig_gen_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int SAMPLE_W   = 16,
  parameter int AMP_W      = 16,
  parameter int DUTY_W     = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sample_tick,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_voice,
  input  logic [1:0]                 wr_addr,
  input  logic [31:0]                wr_data,
  input  logic                       clr_overrun,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int NP_W   = SUM_W + RECIP_W + 1;
  localparam int NS_W   = SUM_W + 2;
  localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(NUM_VOICES - 1);
  localparam logic signed [NS_W-1:0] SAT_MAX = {{(NS_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [NS_W-1:0] SAT_MIN = {{(NS_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  // Voice register file and phase state
  logic [PHASE_W-1:0] freq_q  [NUM_VOICES];
  logic [AMP_W-1:0]   amp_q   [NUM_VOICES];
  logic [1:0]         shape_q [NUM_VOICES];
  logic [DUTY_W-1:0]  duty_q  [NUM_VOICES];
  logic               en_q    [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  logic               en_nx_s [NUM_VOICES];

  // Mixer state
  state_e                    state_q;
  logic [VIDX_W-1:0]         vidx_q;
  logic signed [SUM_W-1:0]   sum_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      wr_ok_s;
  logic [VIDX_W-1:0]         wr_idx_s;
  logic                      cur_active_s;
  logic                      slot_s;
  logic                      tick_accept_s;
  logic                      tick_busy_s;
  logic signed [SAMPLE_W-1:0] scaled_s;
  logic signed [SUM_W-1:0]   scaled_ext_s;
  logic [RECIP_W-1:0]        recip_s;
  logic [NP_W-1:0]           sum_ext_s;
  logic [NP_W-1:0]           recip_ext_s;
  logic signed [NP_W-1:0]    nprod_s;
  logic signed [NS_W-1:0]    nshift_s;
  logic signed [SAMPLE_W-1:0] norm_s;

  // Write decode, current-slot status and tick classification
  always_comb begin
    wr_ok_s       = wr_en && ({1'b0, wr_voice} < 5'(NUM_VOICES));
    wr_idx_s      = VIDX_W'(wr_voice);
    cur_active_s  = en_q[vidx_q] && (freq_q[vidx_q] != '0);
    slot_s        = (state_q == ST_ACCUM);
    tick_accept_s = sample_tick && ((state_q == ST_IDLE) || (state_q == ST_OUT));
    tick_busy_s   = sample_tick && ((state_q == ST_ACCUM) || (state_q == ST_NORM));
    scaled_ext_s  = {{(SUM_W-SAMPLE_W){scaled_s[SAMPLE_W-1]}}, scaled_s};
  end

  sig_wave_shaper #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W),
    .AMP_W    (AMP_W),
    .DUTY_W   (DUTY_W)
  ) u_shaper (
    .phase_i  (phase_q[vidx_q]),
    .shape_i  (shape_q[vidx_q]),
    .duty_i   (duty_q[vidx_q]),
    .amp_i    (amp_q[vidx_q]),
    .scaled_o (scaled_s)
  );

  // Next phase: a disabled voice (including one being disabled this edge) parks at 0
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      en_nx_s[i] = en_q[i];
      if (wr_ok_s && (wr_addr == ADDR_CTRL) && (wr_idx_s == VIDX_W'(i))) begin
        en_nx_s[i] = wr_data[CTRL_EN_BIT];
      end else begin
        en_nx_s[i] = en_q[i];
      end
      if (!en_nx_s[i]) begin
        phase_d[i] = '0;
      end else if (slot_s && cur_active_s && (vidx_q == VIDX_W'(i))) begin
        phase_d[i] = phase_q[i] + freq_q[i];
      end else begin
        phase_d[i] = phase_q[i];
      end
    end
  end

  // Normaliser: average via reciprocal multiply, then saturate
  always_comb begin
    recip_s     = recip_lut(5'(cnt_q));
    sum_ext_s   = {{(NP_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
    recip_ext_s = {{(NP_W-RECIP_W){1'b0}}, recip_s};
    nprod_s     = $signed(sum_ext_s) * $signed(recip_ext_s);
    nshift_s    = NS_W'(nprod_s >>> 16);
    if (cnt_q == '0) begin
      norm_s = '0;
    end else if (nshift_s > SAT_MAX) begin
      norm_s = SAMPLE_W'(SAT_MAX);
    end else if (nshift_s < SAT_MIN) begin
      norm_s = SAMPLE_W'(SAT_MIN);
    end else begin
      norm_s = SAMPLE_W'(nshift_s);
    end
  end

  // Voice register file: commit host writes to in-range voices
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq_q[i]  <= '0;
        amp_q[i]   <= '0;
        shape_q[i] <= 2'd0;
        duty_q[i]  <= '0;
        en_q[i]    <= 1'b0;
      end
    end else if (wr_ok_s) begin
      case (wr_addr)
        ADDR_FREQ: freq_q[wr_idx_s] <= PHASE_W'(wr_data);
        ADDR_AMP:  amp_q[wr_idx_s]  <= AMP_W'(wr_data);
        ADDR_CTRL: begin
          shape_q[wr_idx_s] <= wr_data[CTRL_SHAPE_LSB +: 2];
          duty_q[wr_idx_s]  <= DUTY_W'(wr_data >> CTRL_DUTY_LSB);
          en_q[wr_idx_s]    <= wr_data[CTRL_EN_BIT];
        end
        default: ;
      endcase
    end
  end

  // Phase accumulators
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= phase_d[i];
      end
    end
  end

  // Mix sequencer: IDLE -> ACCUM (one voice per cycle) -> NORM -> OUT, registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      vidx_q       <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (tick_busy_s) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
      case (state_q)
        ST_IDLE, ST_OUT: begin
          if (tick_accept_s) begin
            state_q <= ST_ACCUM;
            busy    <= 1'b1;
            vidx_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (cur_active_s) begin
            sum_q <= sum_q + scaled_ext_s;
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (vidx_q == VIDX_LAST) begin
            state_q <= ST_NORM;
          end else begin
            vidx_q <= vidx_q + VIDX_W'(1);
          end
        end
        ST_NORM: begin
          sample       <= norm_s;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state_q      <= ST_OUT;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sig_gen.sv
`timescale 1ns/1ps
// Directed self-checking bench for poly_sig_gen (4 voices, 16-bit samples).
module tb_poly_sig_gen;

  logic               clk;
  logic               rstn;
  logic               sample_tick;
  logic               wr_en;
  logic [3:0]         wr_voice;
  logic [1:0]         wr_addr;
  logic [31:0]        wr_data;
  logic               clr_overrun;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               busy;
  logic               overrun;

  int errors;
  int checks;

  poly_sig_gen #(
    .NUM_VOICES (4),
    .PHASE_W    (32),
    .SAMPLE_W   (16),
    .AMP_W      (16),
    .DUTY_W     (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_tick  (sample_tick),
    .wr_en        (wr_en),
    .wr_voice     (wr_voice),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clr_overrun  (clr_overrun),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] v, input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_voice = v; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Tick, then wait (bounded) for sample_valid; lat counts cycles after the accepting edge.
  task automatic do_tick(output int lat, output int smp);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    lat = 0; smp = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sample_valid) begin
        lat = k; smp = int'(sample);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic tick_expect(input string tag, input int exp);
    int lat, smp;
    do_tick(lat, smp);
    check_eq({tag, "_lat"}, lat, 6);
    check_eq(tag, smp, exp);
  endtask

  initial begin
    int w, e, lat, smp, busy_n, val_at, val_n, val2;
    errors = 0; checks = 0;
    rstn = 1'b0; sample_tick = 1'b0; wr_en = 1'b0; wr_voice = 4'd0;
    wr_addr = 2'd0; wr_data = 32'd0; clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_eq("rst_sample", int'(sample), 0);
    check_eq("rst_valid", int'(sample_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1;

    // 1: single SAW_UP voice, 17 ticks with wrap
    wr(4'd0, 2'd0, 32'h1000_0000);
    wr(4'd0, 2'd1, 32'h0000_FFFF);
    wr(4'd0, 2'd2, 32'h8000_0000);
    for (int k = 1; k <= 17; k++) begin
      w = (k == 17) ? -32768 : (-32768 + 4096 * (k - 1));
      e = (w > 0) ? (w - 1) : w;
      tick_expect($sformatf("saw_up_%0d", k), e);
    end

    // 2: SQUARE duty 128, then add v1 SAW_UP -> average of 32766 and -32768
    wr(4'd0, 2'd2, 32'h0000_0000);
    wr(4'd0, 2'd2, 32'h8000_0203);
    tick_expect("square_pos", 32766);
    wr(4'd1, 2'd0, 32'h1000_0000);
    wr(4'd1, 2'd1, 32'h0000_FFFF);
    wr(4'd1, 2'd2, 32'h8000_0000);
    tick_expect("mix_two", -1);

    // Other shapes on v0 alone: TRI, SAW_DN with half amplitude, SQUARE duty 0
    wr(4'd1, 2'd2, 32'h0000_0000);
    wr(4'd0, 2'd2, 32'h0000_0000);
    wr(4'd0, 2'd2, 32'h8000_0002);
    tick_expect("tri_0", -32768);
    tick_expect("tri_1", -24576);
    wr(4'd0, 2'd2, 32'h0000_0000);
    wr(4'd0, 2'd2, 32'h8000_0001);
    tick_expect("saw_dn_0", 32766);
    wr(4'd0, 2'd1, 32'h0000_8000);
    tick_expect("saw_dn_half", 14335);
    wr(4'd0, 2'd1, 32'h0000_FFFF);
    wr(4'd0, 2'd2, 32'h8000_0003);
    tick_expect("square_neg", -32767);

    // 3: latency/busy window and back-to-back tick in the valid cycle
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    busy_n = 0; val_at = 0; val_n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (sample_valid) begin val_at = k; val_n++; end
    end
    check_eq("busy_cycles", busy_n, 5);
    check_eq("valid_at", val_at, 6);
    check_eq("valid_count", val_n, 1);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    val2 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sample_valid && (val2 == 0)) val2 = k;
    end
    check_eq("b2b_valid_at", val2, 6);
    @(posedge clk); #1;

    // 4: tick while busy -> single sample, sticky overrun until cleared
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    val_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sample_valid) val_n++;
      if (k == 3) begin
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
      end
    end
    check_eq("overrun_valid_count", val_n, 1);
    check_eq("overrun_set", int'(overrun), 1);
    @(posedge clk); #1;
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    @(negedge clk);
    check_eq("overrun_clr", int'(overrun), 0);
    @(posedge clk); #1;

    // 5: reset in the middle of a mix (sample currently nonzero)
    check_eq("pre_rst_sample", int'(sample), -32767);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    val_n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (sample_valid) val_n++;
    end
    check_eq("midrst_no_valid", val_n, 0);
    check_eq("midrst_sample", int'(sample), 0);
    check_eq("midrst_busy", int'(busy), 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    tick_expect("post_rst_empty", 0);

    // 6: out-of-range voice writes are dropped; re-enable restarts phase
    wr(4'd0, 2'd0, 32'h1000_0000);
    wr(4'd0, 2'd1, 32'h0000_FFFF);
    wr(4'd0, 2'd2, 32'h8000_0000);
    wr(4'd5, 2'd0, 32'h0000_0001);
    wr(4'd5, 2'd1, 32'h0000_FFFF);
    wr(4'd5, 2'd2, 32'h8000_03FF);
    wr(4'd4, 2'd1, 32'h0000_0000);
    tick_expect("bad_voice_0", -32768);
    tick_expect("bad_voice_1", -28672);
    wr(4'd0, 2'd2, 32'h0000_0000);
    wr(4'd0, 2'd2, 32'h8000_0000);
    tick_expect("reenable", -32768);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
